// File: rtl/word_unpack_32.sv
// Unpacks 32-bit words into an MSB-first byte stream with valid/ready on both sides.
// Optional macro WORD_UNPACK_PIPE_EN lets a new word load on the last-byte edge (no bubble).
module word_unpack_32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               accept, consume, last_idx;

  // State, hold and index registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  // Handshakes, next state and outputs.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    last_idx  = (idx_q == IDX_W'(3));
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_last  = out_valid & last_idx;
`ifdef WORD_UNPACK_PIPE_EN
    in_ready  = ~clr & ((state_q == IDLE) | ((state_q == SEND) & last_idx & out_ready));
`else
    in_ready  = ~clr & (state_q == IDLE);
`endif
    accept    = in_valid & in_ready;
    consume   = out_valid & out_ready;

    if (consume) begin
      idx_d = idx_q + IDX_W'(1);
      if (last_idx) state_d = IDLE;
    end
    // A load wins over the last-byte return to IDLE.
    if (accept) begin
      hold_d  = in_data;
      idx_d   = '0;
      state_d = SEND;
    end

    case (idx_q)
      2'd0:    out_byte = hold_q[31:24];
      2'd1:    out_byte = hold_q[23:16];
      2'd2:    out_byte = hold_q[15:8];
      default: out_byte = hold_q[BYTE_W-1:0];
    endcase
  end

endmodule

// File: tb/tb_word_unpack_32.sv
// Directed bench for word_unpack_32: per-cycle vector table plus reset and mutation sequences.
module tb_word_unpack_32;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  word_unpack_32 dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_byte(out_byte),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [31:0] data;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [7:0]  b;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic c, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic ir, input logic ov,
                              input logic [7:0] b, input logic last, input logic bs);
    vec_t v;
    v.clr = c; v.iv = iv; v.data = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.b = b; v.last = last; v.busy = bs;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic c, input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    clr = c; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic check(input string name, input logic ir, input logic ov,
                       input logic [7:0] b, input logic last, input logic bs);
    logic [11:0] act, exp;
    act = {in_ready, out_valid, out_byte, out_last, busy};
    exp = {ir, ov, b, last, bs};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got ir=%b ov=%b byte=%h last=%b busy=%b, want ir=%b ov=%b byte=%h last=%b busy=%b",
               name, in_ready, out_valid, out_byte, out_last, busy, ir, ov, b, last, bs);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;

    // Second reset cycle with in_valid high: nothing may be accepted.
    add(1, 1, 32'hFFFF_FFFF, 1,  0, 0, 8'h00, 0, 0);
    add(0, 0, 32'h0,         1,  1, 0, 8'h00, 0, 0);
    // Basic unpack.
    add(0, 1, 32'hDEAD_BEEF, 1,  1, 0, 8'h00, 0, 0);
    add(0, 0, 32'h0,         1,  0, 1, 8'hDE, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hAD, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hBE, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hEF, 1, 1);
    add(0, 0, 32'h0,         1,  1, 0, 8'hDE, 0, 0);
    // Backpressure on byte 34.
    add(0, 1, 32'h1234_5678, 1,  1, 0, 8'hDE, 0, 0);
    add(0, 0, 32'h0,         1,  0, 1, 8'h12, 0, 1);
    add(0, 0, 32'h0,         0,  0, 1, 8'h34, 0, 1);
    add(0, 0, 32'h0,         0,  0, 1, 8'h34, 0, 1);
    add(0, 0, 32'h0,         0,  0, 1, 8'h34, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'h34, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'h56, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'h78, 1, 1);
    add(0, 0, 32'h0,         1,  1, 0, 8'h12, 0, 0);
    // Back-to-back words.
    add(0, 1, 32'h0102_0304, 1,  1, 0, 8'h12, 0, 0);
    add(0, 1, 32'hA0B0_C0D0, 1,  0, 1, 8'h01, 0, 1);
    add(0, 1, 32'hA0B0_C0D0, 1,  0, 1, 8'h02, 0, 1);
    add(0, 1, 32'hA0B0_C0D0, 1,  0, 1, 8'h03, 0, 1);
`ifdef WORD_UNPACK_PIPE_EN
    add(0, 1, 32'hA0B0_C0D0, 1,  1, 1, 8'h04, 1, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hA0, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hB0, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hC0, 0, 1);
    add(0, 0, 32'h0,         1,  1, 1, 8'hD0, 1, 1);
`else
    add(0, 1, 32'hA0B0_C0D0, 1,  0, 1, 8'h04, 1, 1);
    add(0, 1, 32'hA0B0_C0D0, 1,  1, 0, 8'h01, 0, 0);
    add(0, 0, 32'h0,         1,  0, 1, 8'hA0, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hB0, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hC0, 0, 1);
    add(0, 0, 32'h0,         1,  0, 1, 8'hD0, 1, 1);
`endif
    add(0, 0, 32'h0,         1,  1, 0, 8'hA0, 0, 0);

    @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].clr, vq[i].iv, vq[i].data, vq[i].ordy);
      check($sformatf("vec%0d", i), vq[i].ir, vq[i].ov, vq[i].b, vq[i].last, vq[i].busy);
    end

    // Mid-word reset: drop CAFEF00D after two bytes.
    drive(0, 1, 32'hCAFE_F00D, 1); check("mw_accept", 1, 0, 8'hA0, 0, 0);
    drive(0, 0, 32'h0, 1);         check("mw_ca",     0, 1, 8'hCA, 0, 1);
    drive(0, 0, 32'h0, 1);         check("mw_fe",     0, 1, 8'hFE, 0, 1);
    drive(1, 1, 32'h1234_5678, 1); check("mw_clr",    0, 1, 8'hF0, 0, 1);
    drive(0, 0, 32'h0, 1);         check("mw_zero",   1, 0, 8'h00, 0, 0);
    drive(0, 1, 32'h0000_0011, 1); check("mw_acc2",   1, 0, 8'h00, 0, 0);
    drive(0, 0, 32'h0, 1);         check("mw_b0",     0, 1, 8'h00, 0, 1);
    drive(0, 0, 32'h0, 1);         check("mw_b1",     0, 1, 8'h00, 0, 1);
    drive(0, 0, 32'h0, 1);         check("mw_b2",     0, 1, 8'h00, 0, 1);
    drive(0, 0, 32'h0, 1);         check("mw_b3",     0, 1, 8'h11, 1, 1);
    drive(0, 0, 32'h0, 1);         check("mw_idle",   1, 0, 8'h00, 0, 0);

    // in_data churns after acceptance; bytes must come from the captured word.
    drive(0, 1, 32'h89AB_CDEF, 1); check("mut_accept", 1, 0, 8'h00, 0, 0);
    drive(0, 0, 32'($urandom), 1); check("mut_89", 0, 1, 8'h89, 0, 1);
    drive(0, 0, 32'($urandom), 1); check("mut_ab", 0, 1, 8'hAB, 0, 1);
    drive(0, 0, 32'($urandom), 1); check("mut_cd", 0, 1, 8'hCD, 0, 1);
    drive(0, 0, 32'($urandom), 1); check("mut_ef", 0, 1, 8'hEF, 1, 1);
    drive(0, 0, 32'($urandom), 1); check("mut_idle", 1, 0, 8'h89, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
